bcd_counter_7seg: RTL and testbench

Multi-digit BCD up-counter with a multiplexed, active-low 7-segment display driver. It sits directly downstream of the push-button increment FSM. Each cycle its single-cycle increment pulse is high, the count advances by one. The counter value is scanned onto the board's common-anode display, one digit at a time.

---
 rtl/bcd_counter_7seg.sv | 124 ++++++++++++
 tb/tb_bcd_counter_7seg.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_7seg.sv
// bcd_counter_7seg: N-digit BCD up-counter driven by a single-cycle increment
// pulse, with a time-multiplexed, active-low common-anode 7-segment driver.
// Optional leading-zero blanking; the decimal point is held off.
module bcd_counter_7seg #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_CYCLES = 100000,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inc_pulse,
    input  logic                    clear,
    output logic [4*N_DIGITS-1:0]   count_bcd,
    output logic                    overflow,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    seg_pattern = 7'b1000000;
            4'd1:    seg_pattern = 7'b1111001;
            4'd2:    seg_pattern = 7'b0100100;
            4'd3:    seg_pattern = 7'b0110000;
            4'd4:    seg_pattern = 7'b0011001;
            4'd5:    seg_pattern = 7'b0010010;
            4'd6:    seg_pattern = 7'b0000010;
            4'd7:    seg_pattern = 7'b1111000;
            4'd8:    seg_pattern = 7'b0000000;
            4'd9:    seg_pattern = 7'b0010000;
            default: seg_pattern = 7'b1111111;
        endcase
    endfunction

    logic [4*N_DIGITS-1:0] count_next;
    logic                  carry;
    logic                  wrap;
    logic [REF_W-1:0]      refresh_q;
    logic [IDX_W-1:0]      idx_q;
    logic [3:0]            cur_digit;
    logic                  upper_nz;
    logic                  blank;
    logic [N_DIGITS-1:0]   an_next;
    logic [6:0]            seg_next;

    assign dp = 1'b1;

    // Ripple the increment through the BCD digit chain; carry out of the top digit is the wrap
    always_comb begin
        count_next = count_bcd;
        carry      = inc_pulse;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (carry) begin
                if (count_bcd[4*i +: 4] == 4'd9) begin
                    count_next[4*i +: 4] = '0;
                end else begin
                    count_next[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
        wrap = carry;
    end

    // Count register and overflow pulse; clear outranks increment
    always_ff @(posedge clk) begin
        if (rst) begin
            count_bcd <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            count_bcd <= '0;
            overflow  <= 1'b0;
        end else begin
            count_bcd <= count_next;
            overflow  <= wrap;
        end
    end

    // Free-running refresh timer and digit scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            idx_q     <= '0;
        end else if (refresh_q == REF_LAST) begin
            refresh_q <= '0;
            idx_q     <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    // Select the scanned digit and decide whether it is a leading zero to blank
    always_comb begin
        cur_digit = count_bcd[idx_q*4 +: 4];
        upper_nz  = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (IDX_W'(i) >= idx_q && count_bcd[4*i +: 4] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end
        blank    = BLANK_LZ && (idx_q != '0) && !upper_nz;
        seg_next = blank ? 7'b1111111 : seg_pattern(cur_digit);
        an_next  = ~(N_DIGITS'(1) << idx_q);
    end

    // Register the display outputs one cycle behind index and count
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= '1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_counter_7seg.sv
// tb_bcd_counter_7seg: directed stimulus with a queue-based scoreboard.
// Stimulus pushes expectations; a monitor on the falling edge pops and compares.
module tb_bcd_counter_7seg;

    localparam int N = 4;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           inc_pulse = 1'b0;
    logic           clear = 1'b0;
    logic [4*N-1:0] count_bcd, count_bcd2;
    logic           overflow, overflow2;
    logic [N-1:0]   an, an2;
    logic [6:0]     seg, seg2;
    logic           dp, dp2;

    bcd_counter_7seg #(.N_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .rst(rst), .inc_pulse(inc_pulse), .clear(clear),
        .count_bcd(count_bcd), .overflow(overflow), .an(an), .seg(seg), .dp(dp)
    );

    bcd_counter_7seg #(.N_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_LZ(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .inc_pulse(inc_pulse), .clear(clear),
        .count_bcd(count_bcd2), .overflow(overflow2), .an(an2), .seg(seg2), .dp(dp2)
    );

    always #5 clk = ~clk;

    typedef enum int {S_CNT, S_OV, S_AN, S_SEG, S_DP, S_AN2, S_SEG2} sel_t;
    typedef struct {
        string       name;
        sel_t        sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   model  = 0;
    bit   model_ov = 1'b0;
    int   cyc    = 0;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic expect_val(input string n, input sel_t s, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.sel  = s;
        c.exp  = e;
        q.push_back(c);
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                c = q.pop_front();
                case (c.sel)
                    S_CNT:  act = 32'(count_bcd);
                    S_OV:   act = 32'(overflow);
                    S_AN:   act = 32'(an);
                    S_SEG:  act = 32'(seg);
                    S_DP:   act = 32'(dp);
                    S_AN2:  act = 32'(an2);
                    S_SEG2: act = 32'(seg2);
                    default: act = 'x;
                endcase
                checks++;
                if (act !== c.exp) begin
                    errors++;
                    $display("FAIL %s at t=%0t: got %h expected %h", c.name, $time, act, c.exp);
                end
            end
        end
    end

    // One clock with the given inputs; update the decimal model and queue count/overflow checks
    task automatic step(input logic i, input logic c);
        inc_pulse = i;
        clear     = c;
        @(posedge clk);
        #1;
        model_ov = 1'b0;
        if (rst) begin
            cyc   = 0;
            model = 0;
        end else begin
            cyc++;
            if (c) model = 0;
            else if (i) begin
                if (model == 9999) begin
                    model    = 0;
                    model_ov = 1'b1;
                end else begin
                    model++;
                end
            end
        end
        expect_val("count_bcd", S_CNT, to_bcd(model));
        expect_val("overflow", S_OV, 32'(model_ov));
    endtask

    // Display expectations for a steady count: digit under scan derived from edges since reset
    task automatic chk_disp();
        int d, p, dv;
        logic [3:0] an_e;
        p  = 1;
        d  = ((cyc - 1) / R) % N;
        for (int k = 0; k < d; k++) p = p * 10;
        dv   = (model / p) % 10;
        an_e = ~(4'b0001 << d);
        expect_val("an", S_AN, 32'(an_e));
        expect_val("an_noblank", S_AN2, 32'(an_e));
        if (d != 0 && (model / p) == 0) expect_val("seg_blank", S_SEG, 32'(7'b1111111));
        else                            expect_val("seg", S_SEG, 32'(seg_of(dv)));
        expect_val("seg_noblank", S_SEG2, 32'(seg_of(dv)));
        expect_val("dp", S_DP, 32'd1);
    endtask

    initial begin
        // Reset held for 3 cycles
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_val("rst_count", S_CNT, 32'h0);
        expect_val("rst_overflow", S_OV, 32'h0);
        expect_val("rst_an", S_AN, 32'hF);
        expect_val("rst_seg", S_SEG, 32'h7F);
        expect_val("rst_dp", S_DP, 32'h1);

        // Release; scan order and dwell over 32 cycles at count 0000
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            step(1'b0, 1'b0);
            chk_disp();
        end

        // Carry chain: 10 spaced pulses, then 90 consecutive
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0);
            repeat (4) step(1'b0, 1'b0);
        end
        expect_val("count_0010", S_CNT, 32'h0010);
        for (int k = 0; k < 90; k++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        expect_val("count_0100", S_CNT, 32'h0100);

        // Preload 9998, then two pulses to wrap
        for (int k = 0; k < 9898; k++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        expect_val("count_9998", S_CNT, 32'h9998);
        step(1'b1, 1'b0);
        expect_val("count_9999", S_CNT, 32'h9999);
        step(1'b1, 1'b0);
        expect_val("wrap_count", S_CNT, 32'h0000);
        expect_val("wrap_overflow", S_OV, 32'h1);
        step(1'b0, 1'b0);
        expect_val("overflow_one_cycle", S_OV, 32'h0);

        // Clear outranks increment
        for (int k = 0; k < 42; k++) step(1'b1, 1'b0);
        expect_val("count_0042", S_CNT, 32'h0042);
        step(1'b1, 1'b1);
        expect_val("clear_prio_count", S_CNT, 32'h0000);
        expect_val("clear_prio_ov", S_OV, 32'h0);
        step(1'b1, 1'b0);
        expect_val("after_clear_inc", S_CNT, 32'h0001);

        // Blanking at count 0042 over a full scan
        for (int k = 0; k < 41; k++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b0);
            chk_disp();
        end

        // Reset mid-count and mid-scan
        rst = 1'b1;
        step(1'b0, 1'b0);
        expect_val("midrst_an", S_AN, 32'hF);
        expect_val("midrst_seg", S_SEG, 32'h7F);
        rst = 1'b0;
        step(1'b0, 1'b0);
        expect_val("post_rst_an", S_AN, 32'hE);
        expect_val("post_rst_seg", S_SEG, 32'h40);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b0);
            chk_disp();
        end

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
